i2s_stereo_tx: RTL and testbench
================================

Name: i2s_stereo_tx

Overview:
- Parametrised I2S transmitter in slave mode for the MP3 player's audio path.
- The codec drives SCLK and LRCLK into the FPGA. This block generates the codec master clock (MCLK) by a power-of-two divide of the system clock.
- It buffers stereo sample pairs in an internal FIFO and serialises them onto the I2S data line.
- It adds underrun muting and a saturating underrun counter.

Parameters:
- SAMPLE_W, 16: bits per channel sample, MSB-first; range 8..32.
- SLOT_W, 32: SCLK periods per channel slot. SAMPLE_W <= SLOT_W. Slot bits beyond SAMPLE_W are transmitted as 0.
- FIFO_DEPTH, 16: stereo pairs buffered; power of two, >= 2.
- MCLK_DIV_LOG2, 2: i2s_mclk = clk_clk / 2^MCLK_DIV_LOG2; >= 1.

Ports:
- clk_clk  in  1  system clock (50 MHz)
- reset_reset_n  in  1  synchronous active-low reset
- enable  in  1  transmitter enable
- s_data  in  2*SAMPLE_W  stereo pair: {left, right}, left in the upper half
- s_valid  in  1  s_data valid
- s_ready  out  1  = enable & ~full; a push occurs when s_valid & s_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of pairs stored
- underrun_clr  in  1  clears underrun_cnt
- underrun_cnt  out  16  saturating count of frames muted due to an empty FIFO
- i2s_sclk  in  1  bit clock from codec (asynchronous)
- i2s_lrclk  in  1  word clock from codec (asynchronous); 0 = left
- i2s_dout  out  1  serial data to codec
- i2s_mclk  out  1  codec master clock

Behaviour:
- Clocking and reset:
  - Single clock domain clk_clk. Reset is synchronous and active-low, sampled on posedge clk_clk.
  - Reset values: i2s_dout=0, i2s_mclk=0, FIFO empty, fifo_level=0, underrun_cnt=0, shifter=0, load_pending=0, lr_prev=0.
  - Reset mid-frame aborts the word; dout is 0 until the next LRCLK transition loads a new word.
- MCLK:
  - Free-running MCLK_DIV_LOG2-bit counter, incremented every clk_clk cycle.
  - i2s_mclk = counter MSB, so the divide is 2^MCLK_DIV_LOG2 with 50% duty.
  - MCLK runs regardless of enable.
- Synchronisation:
  - i2s_sclk and i2s_lrclk each pass through a 2-flop synchroniser, plus one history flop on SCLK.
  - sclk_rise and sclk_fall are single-cycle strobes from the synchronised SCLK.
  - Requirement: SCLK period >= 8 clk_clk cycles.
- Frame tracking:
  - On sclk_rise, compare synchronised LRCLK with lr_prev. If they differ, set load_pending and record new_lr; lr_prev <= LRCLK.
- Shifter (SLOT_W bits), updated on sclk_fall:
  - If load_pending: load {channel sample, (SLOT_W-SAMPLE_W) zeros}; i2s_dout <= sample MSB; clear load_pending.
  - Otherwise: i2s_dout <= shifter MSB, shift left by one, fill with 0.
  - Result: MSB appears on the first falling edge after the LRCLK transition, i.e. one SCLK after, per I2S.
- Channel selection:
  - A load with new_lr=0 (left) pops one pair from the FIFO into a held register and transmits left.
  - A load with new_lr=1 transmits the held right sample. No pop occurs on right loads.
- Underrun:
  - A left load with an empty FIFO sets the held pair to {0,0}, so the whole frame is muted.
  - underrun_cnt increments, saturating at 16'hFFFF.
  - underrun_clr in the same cycle as an increment gives 0; clear wins.
- FIFO:
  - Circular buffer with wrap-around pointers. fifo_level is registered.
  - Push when full is refused (s_ready=0), even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full and not empty: level unchanged, both take effect.
  - Pop and push in the same cycle on an empty FIFO: the pop sees empty (underrun), then the push stores; level becomes 1.
- Enable:
  - enable=0: FIFO flushed (level 0), load_pending cleared, i2s_dout held 0, no pops, no underrun counting.
  - On enable rising, transmission starts at the next LRCLK transition. A right load before the first left load transmits 0.
- Latency: from a push into an empty FIFO, data is output at the next left-channel load.

Test Plan:
- Reset, enable=1, push {16'hA5C3, 16'h0F0F}; codec at SCLK = clk/16, SLOT_W=32 -> left slot dout = 1010010111000011 followed by 16 zeros, MSB one SCLK after LRCLK falls; right slot = 0000111100001111 followed by zeros; fifo_level 1 -> 0 at the left load.
- No pushes for 3 frames -> dout constant 0, underrun_cnt = 3; assert underrun_clr on the cycle of the 4th increment -> underrun_cnt = 0.
- Push 16 pairs with codec idle -> fifo_level = 16, s_ready = 0; 17th s_valid is ignored; one frame later -> level 15, and the transmitted left sample equals the first pushed pair.
- Hold s_valid with a pop in the same cycle at level 5 -> level stays 5; data order preserved across pointer wrap after 40 pairs.
- MCLK_DIV_LOG2=2 -> i2s_mclk period = 4 clk_clk cycles, high 2 cycles; 0 during reset.
- Deassert enable mid-left-slot -> dout 0 on the next sclk_fall, fifo_level 0; re-enable -> first non-zero bit only after the next LRCLK falling transition.

Source files
------------

// File: rtl/i2s_stereo_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_stereo_tx : slave-mode I2S stereo transmitter with pair FIFO, MCLK
//                 divider, underrun muting and saturating underrun counter.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module i2s_stereo_tx #(
  parameter int SAMPLE_W      = 16,
  parameter int SLOT_W        = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int MCLK_DIV_LOG2 = 2
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          enable,
  input  logic [2*SAMPLE_W-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          underrun_clr,
  output logic [15:0]                   underrun_cnt,
  input  logic                          i2s_sclk,
  input  logic                          i2s_lrclk,
  output logic                          i2s_dout,
  output logic                          i2s_mclk
);

  localparam int                    c_ADDR_W   = $clog2(FIFO_DEPTH);
  localparam logic [c_ADDR_W:0]     c_LVL_FULL = (c_ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [c_ADDR_W:0]     c_LVL_ONE  = (c_ADDR_W+1)'(1);
  localparam logic [c_ADDR_W-1:0]   c_PTR_ONE  = c_ADDR_W'(1);

  logic [MCLK_DIV_LOG2-1:0] r_mclk_cnt;
  logic                     r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic                     r_lr_s1, r_lr_s2, r_lr_prev;
  logic                     r_load_pending, r_new_lr;
  logic [SLOT_W-1:0]        r_shift;
  logic                     r_dout;
  logic [SAMPLE_W-1:0]      r_held_right;
  logic [2*SAMPLE_W-1:0]    r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [c_ADDR_W:0]        r_level;
  logic [15:0]              r_ucnt;

  logic                     w_sclk_rise, w_sclk_fall;
  logic                     w_full, w_empty, w_push, w_pop;
  logic                     w_load, w_left_load, w_underrun;
  logic [SAMPLE_W-1:0]      w_sample;
  logic [SLOT_W-1:0]        w_word;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) r_mclk_cnt <= '0;
    else                r_mclk_cnt <= r_mclk_cnt + MCLK_DIV_LOG2'(1);
  end

  assign i2s_mclk = r_mclk_cnt[MCLK_DIV_LOG2-1];

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
    end else begin
      r_sclk_s1 <= i2s_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_lr_s1   <= i2s_lrclk;
      r_lr_s2   <= r_lr_s1;
    end
  end

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;

  assign w_full      = (r_level == c_LVL_FULL);
  assign w_empty     = (r_level == '0);
  assign s_ready     = enable & ~w_full;
  assign w_push      = s_valid & s_ready;
  assign w_load      = w_sclk_fall & r_load_pending & enable;
  assign w_left_load = w_load & ~r_new_lr;
  assign w_pop       = w_left_load & ~w_empty;
  assign w_underrun  = w_left_load & w_empty;

  // An empty FIFO on a left load mutes the whole frame: left is 0 now, right is held at 0
  assign w_sample = r_new_lr ? r_held_right :
                    (w_empty ? '0 : r_mem[r_rd_ptr][2*SAMPLE_W-1:SAMPLE_W]);
  assign w_word   = SLOT_W'(w_sample) << (SLOT_W - SAMPLE_W);

  // LRCLK is tracked even while disabled so a re-enable waits for a fresh transition
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_lr_prev      <= 1'b0;
      r_load_pending <= 1'b0;
      r_new_lr       <= 1'b0;
    end else begin
      if (w_sclk_rise) r_lr_prev <= r_lr_s2;
      if (!enable) begin
        r_load_pending <= 1'b0;
      end else if (w_sclk_rise && (r_lr_s2 != r_lr_prev)) begin
        r_load_pending <= 1'b1;
        r_new_lr       <= r_lr_s2;
      end else if (w_load) begin
        r_load_pending <= 1'b0;
      end
    end
  end

  // The MSB leaves on the load edge itself, so the shifter keeps only the remaining bits
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || !enable) begin
      r_shift <= '0;
      r_dout  <= 1'b0;
    end else if (w_load) begin
      r_dout  <= w_word[SLOT_W-1];
      r_shift <= w_word << 1;
    end else if (w_sclk_fall) begin
      r_dout  <= r_shift[SLOT_W-1];
      r_shift <= r_shift << 1;
    end
  end

  assign i2s_dout = r_dout;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || !enable) begin
      r_held_right <= '0;
    end else if (w_left_load) begin
      r_held_right <= w_empty ? '0 : r_mem[r_rd_ptr][SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || !enable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  assign fifo_level = r_level;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || underrun_clr) begin
      r_ucnt <= '0;
    end else if (w_underrun && (r_ucnt != 16'hFFFF)) begin
      r_ucnt <= r_ucnt + 16'd1;
    end
  end

  assign underrun_cnt = r_ucnt;

endmodule
`default_nettype wire

// File: tb/tb_i2s_stereo_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_i2s_stereo_tx : codec-model bench for i2s_stereo_tx with a pair scoreboard.
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_i2s_stereo_tx;

  localparam int SAMPLE_W      = 16;
  localparam int SLOT_W        = 32;
  localparam int FIFO_DEPTH    = 16;
  localparam int MCLK_DIV_LOG2 = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  fifo_level;
  logic        underrun_clr;
  logic [15:0] underrun_cnt;
  logic        i2s_sclk;
  logic        i2s_lrclk;
  logic        i2s_dout;
  logic        i2s_mclk;

  always #5 clk = ~clk;

  i2s_stereo_tx #(
    .SAMPLE_W      (SAMPLE_W),
    .SLOT_W        (SLOT_W),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .MCLK_DIV_LOG2 (MCLK_DIV_LOG2)
  ) u_dut (
    .clk_clk       (clk),
    .reset_reset_n (reset_n),
    .enable        (enable),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .fifo_level    (fifo_level),
    .underrun_clr  (underrun_clr),
    .underrun_cnt  (underrun_cnt),
    .i2s_sclk      (i2s_sclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_dout      (i2s_dout),
    .i2s_mclk      (i2s_mclk)
  );

  typedef struct {
    logic [31:0] pair;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          half   = 8;
  int          hook_sel = 0;
  logic [31:0] hook_data = '0;
  logic [31:0] sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One SCLK period: fall (LRCLK changes here), sample dout just before the rise.
  task automatic codec_bit(input logic lr, input bit hook, output logic smp);
    @(negedge clk);
    i2s_sclk  = 1'b0;
    i2s_lrclk = lr;
    for (int j = 1; j < half; j++) begin
      @(negedge clk);
      if (hook) begin
        if (j == 2) begin
          if (hook_sel == 1) begin
            check("pp_level_before", {59'd0, fifo_level}, 64'd5);
            s_valid = 1'b1;
            s_data  = hook_data;
          end else begin
            underrun_clr = 1'b1;
          end
        end else if (j == 3) begin
          s_valid      = 1'b0;
          underrun_clr = 1'b0;
          if (hook_sel == 1) begin
            sb.push_back(hook_data);
            check("pp_level_same_cycle", {59'd0, fifo_level}, 64'd5);
          end
        end
      end
    end
    @(negedge clk);
    smp      = i2s_dout;
    i2s_sclk = 1'b1;
    for (int j = 1; j < half; j++) @(negedge clk);
  endtask

  // Frame from left bit 1 through bit 0 of the next left slot; 64 samples give {L, R}.
  task automatic run_frame(input int hsel, output logic [31:0] l, output logic [31:0] r);
    logic [63:0] st;
    logic        smp;
    st       = '0;
    hook_sel = hsel;
    for (int b = 1; b < 32; b++) begin
      codec_bit(1'b0, (b == 1) && (hsel != 0), smp);
      st = {st[62:0], smp};
    end
    for (int b = 0; b < 32; b++) begin
      codec_bit(1'b1, 1'b0, smp);
      st = {st[62:0], smp};
    end
    codec_bit(1'b0, 1'b0, smp);
    st       = {st[62:0], smp};
    l        = st[63:32];
    r        = st[31:0];
    hook_sel = 0;
  endtask

  task automatic push_pair(input logic [31:0] d, input bit to_sb);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
    if (to_sb) sb.push_back(d);
  endtask

  task automatic frame_sb(input string name, input int hsel);
    logic [31:0] l, r, e;
    run_frame(hsel, l, r);
    e = (sb.size() == 0) ? 32'h0 : sb.pop_front();
    check({name, "_left"},  {32'd0, l}, {32'd0, e[31:16], 16'h0000});
    check({name, "_right"}, {32'd0, r}, {32'd0, e[15:0], 16'h0000});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t        tbl[5];
    logic [31:0] l, r;
    logic [11:0] mpat;
    logic [3:0]  mrst;
    logic        smp;
    int          ones, zeros;

    tbl[0] = '{32'hA5C3_0F0F, 32'hA5C3_0000, 32'h0F0F_0000};
    tbl[1] = '{32'h8001_7FFE, 32'h8001_0000, 32'h7FFE_0000};
    tbl[2] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_0000};
    tbl[3] = '{32'h0000_FFFF, 32'h0000_0000, 32'hFFFF_0000};
    tbl[4] = '{32'h1234_5678, 32'h1234_0000, 32'h5678_0000};

    reset_n      = 1'b0;
    enable       = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    underrun_clr = 1'b0;
    i2s_sclk     = 1'b1;
    i2s_lrclk    = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mrst[3-i] = i2s_mclk;
    end
    check("reset_mclk", {60'd0, mrst}, 64'd0);
    check("reset_dout", {63'd0, i2s_dout}, 64'd0);
    check("reset_level", {59'd0, fifo_level}, 64'd0);
    check("reset_underrun", {48'd0, underrun_cnt}, 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      mpat[11-i] = i2s_mclk;
    end
    check("mclk_pattern", {52'd0, mpat}, {52'd0, 12'b0110_0110_0110});

    enable = 1'b1;
    @(negedge clk);
    check("ready_after_enable", {63'd0, s_ready}, 64'd1);

    codec_bit(1'b1, 1'b0, smp);
    codec_bit(1'b0, 1'b0, smp);

    for (int i = 0; i < 5; i++) begin
      push_pair(tbl[i].pair, 1'b0);
      check("tbl_level_pushed", {59'd0, fifo_level}, 64'd1);
      run_frame(0, l, r);
      check("tbl_left", {32'd0, l}, {32'd0, tbl[i].exp_l});
      check("tbl_right", {32'd0, r}, {32'd0, tbl[i].exp_r});
      check("tbl_level_popped", {59'd0, fifo_level}, 64'd0);
    end
    check("no_underrun_yet", {48'd0, underrun_cnt}, 64'd0);

    for (int i = 0; i < 3; i++) begin
      run_frame(0, l, r);
      check("underrun_mute", {l, r}, 64'd0);
    end
    check("underrun_cnt3", {48'd0, underrun_cnt}, 64'd3);
    run_frame(2, l, r);
    check("underrun_clr_wins", {48'd0, underrun_cnt}, 64'd0);
    check("underrun_mute4", {l, r}, 64'd0);

    for (int i = 0; i < 16; i++) push_pair({16'h1000 + 16'(i), 16'h2000 + 16'(i)}, 1'b1);
    check("fill_level", {59'd0, fifo_level}, 64'd16);
    check("fill_ready", {63'd0, s_ready}, 64'd0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    check("full_refuse", {59'd0, fifo_level}, 64'd16);
    frame_sb("fill_first", 0);
    check("fill_level15", {59'd0, fifo_level}, 64'd15);

    for (int i = 0; i < 10; i++) frame_sb("drain", 0);
    check("level5", {59'd0, fifo_level}, 64'd5);
    hook_data = 32'h5A5A_A5A5;
    frame_sb("pp", 1);
    check("pp_level_after", {59'd0, fifo_level}, 64'd5);

    half = 4;
    for (int k = 0; k < 23; k++) begin
      push_pair({16'h4000 + 16'(k), 16'h8000 + 16'(k)}, 1'b1);
      frame_sb("wrap", 0);
    end
    check("wrap_level", {59'd0, fifo_level}, 64'd5);
    for (int i = 0; i < 5; i++) frame_sb("wrap_drain", 0);
    check("drained", {59'd0, fifo_level}, 64'd0);

    push_pair(32'hFFFF_FFFF, 1'b1);
    push_pair(32'h1111_1111, 1'b1);
    check("en_level2", {59'd0, fifo_level}, 64'd2);
    ones = 0;
    for (int b = 1; b <= 10; b++) begin
      codec_bit(1'b0, 1'b0, smp);
      ones += int'(smp);
    end
    check("en_left_msbs", 64'(ones), 64'd10);
    enable = 1'b0;
    sb.delete();
    zeros = 0;
    for (int b = 11; b < 32; b++) begin
      codec_bit(1'b0, 1'b0, smp);
      zeros += int'(smp);
    end
    check("disable_flush", {59'd0, fifo_level}, 64'd0);
    for (int b = 0; b < 16; b++) begin
      codec_bit(1'b1, 1'b0, smp);
      zeros += int'(smp);
    end
    enable = 1'b1;
    push_pair(32'hC003_FFFF, 1'b1);
    for (int b = 16; b < 32; b++) begin
      codec_bit(1'b1, 1'b0, smp);
      zeros += int'(smp);
    end
    codec_bit(1'b0, 1'b0, smp);
    zeros += int'(smp);
    check("quiet_until_lr_fall", 64'(zeros), 64'd0);
    frame_sb("reenable", 0);
    check("final_level", {59'd0, fifo_level}, 64'd0);
    check("final_underrun", {48'd0, underrun_cnt}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
